seq_divider16: RTL and testbench
================================

// Module: seq_divider16
// PURPOSE
//   Multi-cycle restoring divider. It divides the accumulator value by the memory-data value for the DIV instruction.
//   Sits beside the controller. The controller pulses load, then waits for done before returning to fetch.
//   quotient is written back to ACC through the controller's divide path.
// PARAMETERS
//   WIDTH   16   operand, quotient and remainder width in bits. Latency scales with it.
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-low reset (0 = reset)
//   load         in   1      start pulse. Operands are sampled on the rising edge where load=1.
//   dividend     in   WIDTH  numerator (ACC)
//   divisor      in   WIDTH  denominator (MDR)
//   quotient     out  WIDTH  registered result
//   remainder    out  WIDTH  registered remainder
//   done         out  1      level. High from completion until the edge that samples the next load.
//   busy         out  1      high while iterating
//   div_by_zero  out  1      high with done when the sampled divisor was 0
// BEHAVIOUR
//   Clock and reset:
//   - One clock: clk.
//   - Reset is asynchronous and active-low on rst.
//   - rst=0 immediately forces quotient=0, remainder=0, done=0, busy=0, div_by_zero=0 and state=IDLE.
//   - This applies at any time, including mid-division. The result in flight is discarded.
//   FSM states: IDLE, RUN, FIN.
//   - IDLE/FIN + load=1 with divisor!=0:
//     - latch operands
//     - clear the partial remainder
//     - cnt=WIDTH-1
//     - busy=1, done=0
//     - go to RUN
//   - IDLE/FIN + load=1 with divisor==0:
//     - next edge: quotient={WIDTH{1}}, remainder=dividend
//     - div_by_zero=1, done=1
//     - go to FIN (1-cycle latency)
//   - RUN: one restoring step per cycle.
//     - Shift {rem,q} left by 1.
//     - If rem>=divisor: rem-=divisor and set q[0].
//     - Decrement cnt.
//     - On the step with cnt==0: load quotient and remainder, done=1, busy=0, go to FIN.
//   - Latency: done rises exactly WIDTH edges after the load edge (16 for the default).
//   - FIN holds the outputs stable and done high indefinitely.
//   Handshake:
//   - done deasserts on the same edge that samples load.
//   - A poller that checks done on the cycle after load therefore never sees a stale done.
//   - load while busy: abort and restart with the new operands. Latency restarts from that edge.
//   - load held high for several cycles: each edge restarts. The division runs from the last edge.
//   Arithmetic:
//   - Partial remainder is WIDTH+1 bits so the subtract carry is kept.
//   - Output operands are truncated to WIDTH.
//   - Unsigned by default. Operands 0xFFFF are handled as 65535.
// CONFIGURATION
//   DIV_SIGNED_EN defined: operands are two's complement.
//   - Magnitudes are divided unsigned.
//   - Quotient is negated when the operand signs differ (truncation toward zero).
//   - Remainder takes the sign of the dividend.
//   - Sign fix-up is applied in the final RUN step, so latency is unchanged.
//   - The most-negative value / -1 returns the most-negative value, remainder 0, with no flag.
//   DIV_SIGNED_EN undefined: pure unsigned operation and no sign logic.
// STRUCTURE
//   Package div_pkg:
//   - typedef enum {IDLE,RUN,FIN} div_state_t
//   - localparam DIV_W=16
//   - CNT_W=$clog2(DIV_W)
//   Sub-module div_step (combinational):
//   - inputs: one shift/compare/subtract step {rem_in, q_in, divisor}
//   - outputs: {rem_out, q_out}
//   - Instantiated once in RUN. It is the only arithmetic.
// TESTING
//   - rst=0 mid-RUN (cycle 5): all outputs 0 immediately. A later load of 9/3 -> q=3, r=0 after 16 cycles.
//   - load 100/7 -> busy for 16 cycles, then done=1, q=14, r=2. done stays high for 10 idle cycles.
//   - load 1234/0 -> one cycle later done=1, div_by_zero=1, q=0xFFFF, r=1234.
//   - Finish 50/5, then load 7/2 -> done low on the cycle after load. After 16 cycles q=3, r=1.
//   - load 200/3, then load 65535/255 at cycle 6 -> only the second result appears, 16 cycles after the reload: q=257, r=0.
//   - DIV_SIGNED_EN: -7/2 -> q=0xFFFD (-3), r=0xFFFF (-1). 7/-2 -> q=0xFFFD, r=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_W       default operand / quotient / remainder width
//   CNT_W       width of the step counter for DIV_W
//   div_state_t controller states: IDLE, RUN (iterating), FIN (result held)
package div_pkg;
  localparam int DIV_W = 16;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem_in   partial remainder (WIDTH+1 bits, keeps subtract carry)
//   q_in     current quotient/dividend shift register
//   divisor  divisor magnitude
//   rem_out  partial remainder after shift and conditional subtract
//   q_out    q_in shifted left, new quotient bit in bit 0
module div_step import div_pkg::*; #(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] q_out
);
  // Shift {rem,q} left by one; the extra top bit keeps the compare exact
  // for any rem_in, not just the rem<divisor invariant of a clean run.
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] diff;
  logic             take;

  always_comb begin
    rem_sh = {rem_in, q_in[WIDTH-1]};
    diff   = rem_sh - {2'b00, divisor};
    take   = (rem_sh >= {2'b00, divisor});
    if (take) begin
      rem_out = diff[WIDTH:0];
      q_out   = {q_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = rem_sh[WIDTH:0];
      q_out   = {q_in[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/seq_divider16.sv
// Multi-cycle restoring divider for the DIV instruction (ACC / MDR).
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   load           start pulse; operands sampled on the edge where load=1
//   dividend       numerator, divisor denominator
//   quotient       registered result, remainder registered remainder
//   done           high from completion until the edge that samples the next load
//   busy           high while iterating
//   div_by_zero    high with done when the sampled divisor was 0
// Build option: define DIV_SIGNED_EN for two's-complement operands
// (truncating division, remainder takes the dividend's sign).
// done rises exactly WIDTH edges after the load edge; divide-by-zero
// completes on the load edge itself.
module seq_divider16 import div_pkg::*; #(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q, rem_nx;
  logic [WIDTH-1:0] q_q, q_nx;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             zero_dvsr;
  logic             load_nz, load_z, step, last;

  assign zero_dvsr = (divisor == '0);

`ifdef DIV_SIGNED_EN
  logic sgn_a, sgn_b;
  logic neg_q, neg_r;

  assign sgn_a = dividend[WIDTH-1];
  assign sgn_b = divisor[WIDTH-1];
  // Most-negative magnitude wraps to itself, which reads correctly as unsigned.
  assign mag_a = sgn_a ? -dividend : dividend;
  assign mag_b = sgn_b ? -divisor  : divisor;
  assign q_fix = neg_q ? -q_nx : q_nx;
  assign r_fix = neg_r ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
`else
  assign mag_a = dividend;
  assign mag_b = divisor;
  assign q_fix = q_nx;
  assign r_fix = rem_nx[WIDTH-1:0];
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .q_in    (q_q),
    .divisor (dvsr_q),
    .rem_out (rem_nx),
    .q_out   (q_nx)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: load wins in every state, so a load while busy restarts.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = zero_dvsr ? FIN : RUN;
    end else begin
      case (state_q)
        RUN:     if (cnt_q == '0) state_d = FIN;
        FIN:     state_d = FIN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs and datapath controls
  always_comb begin
    busy    = (state_q == RUN);
    done    = (state_q == FIN);
    load_nz = load && !zero_dvsr;
    load_z  = load &&  zero_dvsr;
    step    = !load && (state_q == RUN);
    last    = step && (cnt_q == '0);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else if (load_nz) begin
      rem_q       <= '0;
      q_q         <= mag_a;
      dvsr_q      <= mag_b;
      cnt_q       <= CW'(WIDTH-1);
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= sgn_a ^ sgn_b;
      neg_r       <= sgn_a;
`endif
    end else if (load_z) begin
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (step) begin
      rem_q <= rem_nx;
      q_q   <= q_nx;
      cnt_q <= cnt_q - CW'(1);
      if (last) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider16.sv
module tb_seq_divider16;
  logic        clk, rst, load;
  logic [15:0] dividend, divisor, quotient, remainder;
  logic        done, busy, div_by_zero;
  int          n_cmp, n_err;

  seq_divider16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .load(load), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .done(done), .busy(busy),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1; returns at load edge +1.
  task automatic do_load(input logic [15:0] a, input logic [15:0] b);
    dividend = a; divisor = b; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; load = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({quotient, remainder, done, busy, div_by_zero} !== 35'd0) begin
      n_err++; $display("FAIL reset_state: got q=%h r=%h d=%b b=%b z=%b want all 0",
                        quotient, remainder, done, busy, div_by_zero);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_basic;
    do_load(16'd100, 16'd7);
    n_cmp++;
    if ({busy, done, div_by_zero} !== 3'b100) begin
      n_err++; $display("FAIL basic_start: got b/d/z=%b%b%b want 100", busy, done, div_by_zero);
    end
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done} !== 2'b10) begin
        n_err++; $display("FAIL basic_busy_%0d: got b/d=%b%b want 10", k, busy, done);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, quotient, remainder} !== {2'b01, 16'd14, 16'd2}) begin
      n_err++; $display("FAIL basic_result: got b=%b d=%b q=%0d r=%0d want b=0 d=1 q=14 r=2",
                        busy, done, quotient, remainder);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({done, quotient, remainder} !== {1'b1, 16'd14, 16'd2}) begin
        n_err++; $display("FAIL basic_hold_%0d: got d=%b q=%0d r=%0d want 1 14 2",
                          k, done, quotient, remainder);
      end
    end
  endtask

  task automatic test_mid_reset;
    do_load(16'd100, 16'd7);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({quotient, remainder, done, busy, div_by_zero} !== 35'd0) begin
      n_err++; $display("FAIL midrun_reset: got q=%h r=%h d=%b b=%b z=%b want all 0",
                        quotient, remainder, done, busy, div_by_zero);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++; $display("FAIL reset_discard: got d=%b b=%b want 0 0", done, busy);
    end
    do_load(16'd9, 16'd3);
    repeat (15) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL post_reset_early: got done=%b want 0", done);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, quotient, remainder} !== {1'b1, 16'd3, 16'd0}) begin
      n_err++; $display("FAIL post_reset_9_3: got d=%b q=%0d r=%0d want 1 3 0",
                        done, quotient, remainder);
    end
  endtask

  task automatic test_div_zero;
    do_load(16'd1234, 16'd0);
    n_cmp++;
    if ({done, busy, div_by_zero, quotient, remainder} !== {3'b101, 16'hFFFF, 16'd1234}) begin
      n_err++; $display("FAIL div_zero: got d=%b b=%b z=%b q=%h r=%0d want 1 0 1 ffff 1234",
                        done, busy, div_by_zero, quotient, remainder);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, div_by_zero, quotient} !== {2'b11, 16'hFFFF}) begin
      n_err++; $display("FAIL div_zero_hold: got d=%b z=%b q=%h want 1 1 ffff",
                        done, div_by_zero, quotient);
    end
  endtask

  task automatic test_back_to_back;
    do_load(16'd50, 16'd5);
    n_cmp++;
    if ({done, div_by_zero} !== 2'b00) begin
      n_err++; $display("FAIL b2b_flag_clear: got d=%b z=%b want 0 0", done, div_by_zero);
    end
    repeat (16) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, quotient, remainder} !== {1'b1, 16'd10, 16'd0}) begin
      n_err++; $display("FAIL b2b_first: got d=%b q=%0d r=%0d want 1 10 0", done, quotient, remainder);
    end
    do_load(16'd7, 16'd2);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL b2b_done_drop: got done=%b want 0", done);
    end
    repeat (15) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL b2b_early: got done=%b want 0", done);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, quotient, remainder} !== {1'b1, 16'd3, 16'd1}) begin
      n_err++; $display("FAIL b2b_second: got d=%b q=%0d r=%0d want 1 3 1", done, quotient, remainder);
    end
  endtask

  task automatic test_restart;
    logic [15:0] exp_q, exp_r;
`ifdef DIV_SIGNED_EN
    exp_q = 16'd0; exp_r = 16'hFFFF;   // -1 / 255
`else
    exp_q = 16'd257; exp_r = 16'd0;
`endif
    do_load(16'd200, 16'd3);
    repeat (5) @(posedge clk);
    #1;
    do_load(16'hFFFF, 16'd255);
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done} !== 2'b10) begin
        n_err++; $display("FAIL restart_busy_%0d: got b/d=%b%b want 10", k, busy, done);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, quotient, remainder} !== {1'b1, exp_q, exp_r}) begin
      n_err++; $display("FAIL restart_result: got d=%b q=%0d r=%0d want 1 %0d %0d",
                        done, quotient, remainder, exp_q, exp_r);
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed;
    do_load(16'hFFF9, 16'd2);
    repeat (16) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, quotient, remainder} !== {1'b1, 16'hFFFD, 16'hFFFF}) begin
      n_err++; $display("FAIL signed_m7_2: got d=%b q=%h r=%h want 1 fffd ffff", done, quotient, remainder);
    end
    do_load(16'd7, 16'hFFFE);
    repeat (16) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, quotient, remainder} !== {1'b1, 16'hFFFD, 16'd1}) begin
      n_err++; $display("FAIL signed_7_m2: got d=%b q=%h r=%h want 1 fffd 0001", done, quotient, remainder);
    end
    do_load(16'h8000, 16'hFFFF);
    repeat (16) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, div_by_zero, quotient, remainder} !== {2'b10, 16'h8000, 16'h0000}) begin
      n_err++; $display("FAIL signed_min_m1: got d=%b z=%b q=%h r=%h want 1 0 8000 0000",
                        done, div_by_zero, quotient, remainder);
    end
  endtask
`endif

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_basic();
    test_mid_reset();
    test_div_zero();
    test_back_to_back();
    test_restart();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
